// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage 8-bit pipeline. It owns the
// write-enables and flushes of PC, IF/ID and ID/EX, plus one global freeze
// that holds every pipeline register (EX/MEM and MEM/WB included).
//
// Hazards handled:
//   - post-reset scrub: INIT_CYCLES cycles of forced bubbles
//   - load-use: one-cycle stall with a bubble into ID/EX (r0 never hazards)
//   - taken branch: squash IF/ID and ID/EX
//   - multi-cycle data-memory access: freeze until mem_ready, with a timeout
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   IF_ID_rs/rt         source registers of the instruction in ID
//   IF_ID_uses_rt       ID instruction reads rt
//   ID_EX_rd            destination register of the instruction in EX
//   ID_EX_mem_read      EX instruction is a load
//   branch_taken        branch resolved taken in EX
//   EX_MEM_mem_read/write  MEM-stage load / store
//   mem_ready           data memory completes the current access this cycle
//   pc_write            PC load enable
//   IF_ID_write         IF/ID load enable
//   IF_ID_flush         IF/ID clear to NOP
//   ID_EX_flush         ID/EX clear (bubble)
//   pipe_freeze         hold all pipeline registers
//   mem_req             data memory access request
//   mem_timeout         sticky flag: an access was abandoned
//   stall_cycles        saturating count of cycles with pc_write=0
//   dbg_state           current FSM state (0=INIT, 1=RUN, 2=MEM_WAIT)
//
// Memory handshake: mem_req is the request (valid) and mem_ready the
// completion (ready). An access completes on the rising edge of a cycle in
// which both are high; while mem_req is high and mem_ready is low the
// pipeline is frozen so the MEM-stage request stays stable. If the access
// has not completed after MEM_TIMEOUT frozen cycles it is abandoned, the
// pipeline moves on and mem_timeout is raised until reset.
//
// INIT_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int INIT_CYCLES = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       IF_ID_rs,
    input  logic [2:0]       IF_ID_rt,
    input  logic             IF_ID_uses_rt,
    input  logic [2:0]       ID_EX_rd,
    input  logic             ID_EX_mem_read,
    input  logic             branch_taken,
    input  logic             EX_MEM_mem_read,
    input  logic             EX_MEM_mem_write,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic             mem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // init_cnt runs 0 .. INIT_CYCLES-1 while in INIT
    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    // wait_cnt runs 1 .. MEM_TIMEOUT while in MEM_WAIT
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    state_t              state;
    state_t              state_next;
    logic [INIT_W-1:0]   init_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    logic acc;
    logic lu;

    // Outputs of the normal (unfrozen) branch / load-use / pass priority
    logic run_pc_write;
    logic run_if_id_write;
    logic run_if_id_flush;
    logic run_id_ex_flush;

    // Sequential side effects requested by the next-state logic
    logic wait_load;
    logic wait_inc;
    logic timeout_set;

    assign acc = EX_MEM_mem_read | EX_MEM_mem_write;

    // r0 is hard-wired zero, so a load into it never creates a dependency
    assign lu = ID_EX_mem_read && (ID_EX_rd != 3'd0) &&
                ((ID_EX_rd == IF_ID_rs) ||
                 (IF_ID_uses_rt && (ID_EX_rd == IF_ID_rt)));

    assign dbg_state = state;

    always_comb begin
        run_pc_write    = 1'b1;
        run_if_id_write = 1'b1;
        run_if_id_flush = 1'b0;
        run_id_ex_flush = 1'b0;
        if (branch_taken) begin
            // Squash both younger instructions; the stalled ID instruction
            // of a coincident load-use is wrong-path anyway.
            run_if_id_flush = 1'b1;
            run_id_ex_flush = 1'b1;
        end else if (lu) begin
            // Hold PC and IF/ID one cycle; the bubble clears ID_EX_mem_read.
            run_pc_write    = 1'b0;
            run_if_id_write = 1'b0;
            run_id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_write    = run_pc_write;
        IF_ID_write = run_if_id_write;
        IF_ID_flush = run_if_id_flush;
        ID_EX_flush = run_id_ex_flush;
        pipe_freeze = 1'b0;
        mem_req     = 1'b0;
        wait_load   = 1'b0;
        wait_inc    = 1'b0;
        timeout_set = 1'b0;

        case (state)
            ST_INIT: begin
                // Inputs (mem_ready included) have no effect here.
                pc_write    = 1'b0;
                IF_ID_write = 1'b0;
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                mem_req = acc;
                if (acc && !mem_ready) begin
                    // Freeze dominates: branch/lu stay latched in the frozen
                    // registers and are acted on in the release cycle.
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    IF_ID_flush = 1'b0;
                    ID_EX_flush = 1'b0;
                    wait_load   = 1'b1;
                    state_next  = ST_MEM_WAIT;
                end
            end

            ST_MEM_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_next = ST_RUN;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    // Abandon the access; load data is undefined.
                    timeout_set = 1'b1;
                    state_next  = ST_RUN;
                end else begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    IF_ID_flush = 1'b0;
                    ID_EX_flush = 1'b0;
                    wait_inc    = 1'b1;
                end
            end

            default: begin
                pc_write    = 1'b0;
                IF_ID_write = 1'b0;
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                state_next  = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt <= '0;
        end else if ((state == ST_INIT) && (init_cnt != INIT_LAST)) begin
            init_cnt <= init_cnt + INIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (wait_load) begin
            // The RUN cycle that detected the miss is the first frozen cycle
            wait_cnt <= WAIT_W'(1);
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_timeout <= 1'b0;
        end else if (timeout_set) begin
            mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if ((state != ST_INIT) && !pc_write &&
                     (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Single-cycle RUN behaviour comes from
// a table of {inputs, expected outputs} records; the reset scrub, memory
// waits, freeze dominance, timeout, counter saturation and reset during a
// wait are hand-written sequences. Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge. CNT_W is reduced so the
// saturating stall counter can be driven to its limit in a short run.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int INIT_CYCLES = 3;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 5;
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_MW   = 2'd2;

  // expected output bundles: {pc_write, IF_ID_write, IF_ID_flush,
  //                           ID_EX_flush, pipe_freeze, mem_req}
  localparam logic [5:0] O_INIT      = 6'b001100;
  localparam logic [5:0] O_NORM      = 6'b110000;
  localparam logic [5:0] O_NORM_REQ  = 6'b110001;
  localparam logic [5:0] O_STALL     = 6'b000100;
  localparam logic [5:0] O_STALL_REQ = 6'b000101;
  localparam logic [5:0] O_BR        = 6'b111100;
  localparam logic [5:0] O_BR_REQ    = 6'b111101;
  localparam logic [5:0] O_FRZ       = 6'b000011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]       IF_ID_rs;
  logic [2:0]       IF_ID_rt;
  logic             IF_ID_uses_rt;
  logic [2:0]       ID_EX_rd;
  logic             ID_EX_mem_read;
  logic             branch_taken;
  logic             EX_MEM_mem_read;
  logic             EX_MEM_mem_write;
  logic             mem_ready;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             pipe_freeze;
  logic             mem_req;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [1:0]       dbg_state;

  pipe_hazard_ctrl #(
    .INIT_CYCLES(INIT_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_rs        (IF_ID_rs),
    .IF_ID_rt        (IF_ID_rt),
    .IF_ID_uses_rt   (IF_ID_uses_rt),
    .ID_EX_rd        (ID_EX_rd),
    .ID_EX_mem_read  (ID_EX_mem_read),
    .branch_taken    (branch_taken),
    .EX_MEM_mem_read (EX_MEM_mem_read),
    .EX_MEM_mem_write(EX_MEM_mem_write),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .IF_ID_write     (IF_ID_write),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .pipe_freeze     (pipe_freeze),
    .mem_req         (mem_req),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .dbg_state       (dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       uses_rt;
    logic [2:0] ex_rd;
    logic       ex_mem_read;
    logic       branch;
    logic       mem_rd;
    logic       mem_wr;
    logic       ready;
    logic [5:0] exp_o;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic [2:0] rs, input logic [2:0] rt,
                              input logic uses_rt, input logic [2:0] ex_rd,
                              input logic ex_mem_read, input logic branch,
                              input logic mem_rd, input logic mem_wr,
                              input logic ready, input logic [5:0] exp_o);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.ex_rd = ex_rd;
    v.ex_mem_read = ex_mem_read; v.branch = branch; v.mem_rd = mem_rd;
    v.mem_wr = mem_wr; v.ready = ready; v.exp_o = exp_o;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [5:0]       exp_q[$];
  logic [CNT_W-1:0] exp_stall;
  logic             exp_timeout;
  int               pass_cnt;
  int               total_cnt;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle with inputs already applied: sample on the falling edge,
  // advance the stall model, then move to 1 ns after the next rising edge.
  task automatic cycle(input string name, input logic [5:0] exp_o,
                       input logic [1:0] exp_state, input bit counts);
    @(negedge clk);
    check({name, ".outs"}, 32'({pc_write, IF_ID_write, IF_ID_flush,
                                ID_EX_flush, pipe_freeze, mem_req}), 32'(exp_o));
    check({name, ".state"}, 32'(dbg_state), 32'(exp_state));
    check({name, ".stall"}, 32'(stall_cycles), 32'(exp_stall));
    check({name, ".timeout"}, 32'(mem_timeout), 32'(exp_timeout));
    if (counts && !exp_o[5] && exp_stall != STALL_MAX) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    IF_ID_rs         = v.rs;
    IF_ID_rt         = v.rt;
    IF_ID_uses_rt    = v.uses_rt;
    ID_EX_rd         = v.ex_rd;
    ID_EX_mem_read   = v.ex_mem_read;
    branch_taken     = v.branch;
    EX_MEM_mem_read  = v.mem_rd;
    EX_MEM_mem_write = v.mem_wr;
    mem_ready        = v.ready;
  endtask

  task automatic idle();
    drive(mk(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM));
  endtask

  task automatic set_lu();
    IF_ID_rs       = 3'd3;
    ID_EX_rd       = 3'd3;
    ID_EX_mem_read = 1'b1;
  endtask

  task automatic init_phase(input string name);
    for (int i = 0; i < INIT_CYCLES; i++) begin
      mem_ready = (i % 2 == 0);
      cycle(name, O_INIT, S_INIT, 1'b0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    exp_stall   = '0;
    exp_timeout = 1'b0;

    vecs[0]  = mk(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    vecs[1]  = mk(3'd3, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL);
    vecs[2]  = mk(3'd3, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    vecs[3]  = mk(3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    vecs[4]  = mk(3'd1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL);
    vecs[5]  = mk(3'd1, 3'd5, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    vecs[6]  = mk(3'd3, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BR);
    vecs[7]  = mk(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_NORM_REQ);
    vecs[8]  = mk(3'd2, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_STALL_REQ);
    vecs[9]  = mk(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_NORM);
    vecs[10] = mk(3'd3, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    vecs[11] = mk(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, O_BR_REQ);
    vecs[12] = mk(3'd6, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    vecs[13] = mk(3'd7, 3'd7, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL);

    // Reset with hostile inputs: pending miss, branch and load-use.
    reset = 1'b1;
    idle();
    set_lu();
    branch_taken    = 1'b1;
    EX_MEM_mem_read = 1'b1;
    @(posedge clk);
    #1;
    cycle("reset", O_INIT, S_INIT, 1'b0);
    reset = 1'b0;
    init_phase("init");
    idle();
    cycle("run_start", O_NORM, S_RUN, 1'b1);

    // Single-cycle RUN vectors.
    for (int i = 0; i < NVEC; i++) exp_q.push_back(vecs[i].exp_o);
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      cycle($sformatf("vec%0d", i), exp_q.pop_front(), S_RUN, 1'b1);
    end

    // Load miss: 4 frozen cycles, released in the mem_ready cycle.
    idle();
    EX_MEM_mem_read = 1'b1;
    for (int i = 0; i < 4; i++)
      cycle("mem_wait", O_FRZ, (i == 0) ? S_RUN : S_MW, 1'b1);
    mem_ready = 1'b1;
    cycle("mem_release", O_NORM_REQ, S_MW, 1'b1);
    idle();
    cycle("after_mem", O_NORM, S_RUN, 1'b1);

    // Store miss with branch and load-use pending: no flush while frozen.
    idle();
    EX_MEM_mem_write = 1'b1;
    branch_taken     = 1'b1;
    set_lu();
    for (int i = 0; i < 3; i++)
      cycle("frz_branch", O_FRZ, (i == 0) ? S_RUN : S_MW, 1'b1);
    mem_ready = 1'b1;
    cycle("frz_branch_rel", O_BR_REQ, S_MW, 1'b1);

    // Load-use pending across a freeze is acted on in the release cycle.
    idle();
    EX_MEM_mem_read = 1'b1;
    set_lu();
    for (int i = 0; i < 2; i++)
      cycle("frz_lu", O_FRZ, (i == 0) ? S_RUN : S_MW, 1'b1);
    mem_ready = 1'b1;
    cycle("frz_lu_rel", O_STALL_REQ, S_MW, 1'b1);
    idle();
    cycle("after_frz", O_NORM, S_RUN, 1'b1);

    // Timeout: mem_ready never arrives.
    idle();
    EX_MEM_mem_read = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT; i++)
      cycle("timeout_wait", O_FRZ, (i == 0) ? S_RUN : S_MW, 1'b1);
    cycle("timeout_release", O_NORM_REQ, S_MW, 1'b1);
    exp_timeout = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) cycle("timeout_sticky", O_NORM, S_RUN, 1'b1);

    // Back-to-back load-use stalls drive the counter into saturation.
    idle();
    set_lu();
    for (int i = 0; i < 6; i++) cycle("saturate", O_STALL, S_RUN, 1'b1);
    idle();
    cycle("saturated", O_NORM, S_RUN, 1'b1);

    // Reset while waiting on memory drops the access.
    idle();
    EX_MEM_mem_read = 1'b1;
    cycle("rst_wait0", O_FRZ, S_RUN, 1'b1);
    cycle("rst_wait1", O_FRZ, S_MW, 1'b1);
    reset = 1'b1;
    cycle("rst_in_wait", O_FRZ, S_MW, 1'b0);
    exp_stall   = '0;
    exp_timeout = 1'b0;
    cycle("rst_hold", O_INIT, S_INIT, 1'b0);
    reset = 1'b0;
    init_phase("reinit");
    idle();
    cycle("rerun", O_NORM, S_RUN, 1'b1);
    cycle("rerun2", O_NORM, S_RUN, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
